// File: rtl/dmac_multi_ch_ctrl.sv
// N-channel DMAC main controller: arbitrates peripheral requests, runs the bus
// request/grant handshake and keeps sticky per-channel completion status.
module dmac_multi_ch_ctrl #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned CH_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] DmacReq,
    input  logic              Bus_Grant,
    input  logic              C_config,
    input  logic              ch_done,
    input  logic [NUM_CH-1:0] irq_clr,
    output logic              Bus_Req,
    output logic              hold,
    output logic [NUM_CH-1:0] Channel_en,
    output logic [CH_W-1:0]   con_sel,
    output logic              con_en,
    output logic [NUM_CH-1:0] ReqAck,
    output logic              Interrupt,
    output logic [NUM_CH-1:0] irq_status
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

    state_e            state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   win_idx, sel_inc;
    logic [CH_W:0]     rr_sum;
    logic              win_found;
    logic              acked_q, acked_d;
    logic              interrupt_q, interrupt_d;
    logic              done_evt;
    logic [NUM_CH-1:0] elig, sel_onehot;
    logic [NUM_CH-1:0] req_ack_q, req_ack_d;
    logic [NUM_CH-1:0] status_q, status_d;

    assign elig       = DmacReq & ~status_q;
    assign sel_onehot = NUM_CH'(1) << sel_q;
    assign sel_inc    = (sel_q == CH_W'(NUM_CH - 1)) ? '0 : sel_q + CH_W'(1);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        if (ARB_MODE == 0) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (elig[i]) begin
                    win_found = 1'b1;
                    win_idx   = CH_W'(i);
                end
            end
        end else begin
            // Ascending search from rr_ptr, wrapping modulo NUM_CH
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                rr_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
                if (rr_sum >= (CH_W+1)'(NUM_CH)) begin
                    rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
                end
                if (!win_found && elig[rr_sum[CH_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = rr_sum[CH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        acked_d     = acked_q;
        req_ack_d   = '0;
        interrupt_d = 1'b0;
        done_evt    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    acked_d = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (Bus_Grant && C_config) begin
                    state_d = StXfer;
                    // Acknowledge only on the first entry, not after a grant loss
                    if (!acked_q) begin
                        req_ack_d = sel_onehot;
                        acked_d   = 1'b1;
                    end
                end
            end
            StXfer: begin
                if (ch_done) begin
                    done_evt    = 1'b1;
                    interrupt_d = 1'b1;
                    rr_ptr_d    = sel_inc;
                    state_d     = StIdle;
                end else if (!Bus_Grant) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign status_d = (status_q & ~irq_clr) | (done_evt ? sel_onehot : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            acked_q     <= 1'b0;
            req_ack_q   <= '0;
            interrupt_q <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            acked_q     <= acked_d;
            req_ack_q   <= req_ack_d;
            interrupt_q <= interrupt_d;
            status_q    <= status_d;
        end
    end

    assign Bus_Req    = (state_q != StIdle);
    assign hold       = (state_q != StIdle);
    assign Channel_en = (state_q == StXfer) ? sel_onehot : '0;
    assign con_en     = (state_q == StXfer);
    assign con_sel    = sel_q;
    assign ReqAck     = req_ack_q;
    assign Interrupt  = interrupt_q;
    assign irq_status = status_q;

endmodule

// File: doc/dmac_multi_ch_ctrl.md
# dmac_multi_ch_ctrl

Parametrised N-channel main controller for the AHB DMAC. It arbitrates peripheral DMA requests across `NUM_CH` channels with fixed or round-robin priority. It owns the bus request/grant handshake and the channel-enable and configuration-select outputs. It tracks per-channel completion interrupts in sticky status bits. It sits between the peripheral request lines, the AHB master interface and the per-channel transfer engines, replacing the fixed two-channel controller.

## Interface
- `NUM_CH`, default 4: number of channels. Legal range 2..16.
- `ARB_MODE`, default 0: 0 = fixed priority (highest index wins); 1 = round-robin.
- `CH_W`, default $clog2(NUM_CH): channel index width. Derived; not overridden.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `DmacReq` in NUM_CH: per-peripheral DMA request, level.
- `Bus_Grant` in 1: AHB bus grant to the DMAC master.
- `C_config` in 1: the selected channel's configuration registers are valid.
- `ch_done` in 1: the active channel's transfer is complete. One-cycle pulse from the channel engine.
- `irq_clr` in NUM_CH: per-channel write-1-to-clear of interrupt status.
- `Bus_Req` out 1: bus request to the arbiter.
- `hold` out 1: the DMAC owns or is acquiring the bus.
- `Channel_en` out NUM_CH: one-hot channel enable.
- `con_sel` out CH_W: index of the selected channel's configuration bank.
- `con_en` out 1: configuration bank read enable.
- `ReqAck` out NUM_CH: one-cycle acknowledge to the winning peripheral.
- `Interrupt` out 1: one-cycle completion pulse.
- `irq_status` out NUM_CH: sticky per-channel completion flags.

## Operation
- **Eligibility.** `elig = DmacReq & ~irq_status`. A channel with pending status is not serviced until software clears its status bit.
- **Fixed priority (ARB_MODE=0).** The highest eligible index wins.
- **Round-robin (ARB_MODE=1).** Search starts at `rr_ptr` and ascends, wrapping modulo NUM_CH. The first eligible index wins.
  - On each `ch_done`, `rr_ptr` is set to `(sel+1) mod NUM_CH`.
  - When `sel = NUM_CH-1`, `rr_ptr` wraps to 0.
- **Winner latch.** The winner is latched into `sel` only in IDLE. Requests arriving during REQ or XFER are ignored until the controller returns to IDLE. No preemption.
- **State machine.**
  - IDLE: if `elig != 0`, latch `sel` and go to REQ. Otherwise stay in IDLE.
  - REQ: if `Bus_Grant && C_config`, go to XFER. Otherwise stay in REQ.
  - XFER: if `ch_done`, go to IDLE. Else if `!Bus_Grant`, go to REQ (grant lost; resume the same channel). Else stay in XFER.
- **Simultaneous events in XFER.** If `ch_done` and `!Bus_Grant` occur in the same cycle, `ch_done` wins and the next state is IDLE.
- **Outputs decoded from state and `sel` (Moore).**
  - `Bus_Req = hold = (REQ || XFER)`.
  - `Channel_en = XFER ? (1 << sel) : 0`.
  - `con_en = XFER`.
  - `con_sel = sel` at all times.
- **ReqAck.** A registered one-cycle pulse, `ReqAck[sel] = 1`, in the first XFER cycle after leaving REQ.
  - Issued once per request, on the initial REQ→XFER entry.
  - It is not re-issued after resuming from a grant loss.
- **Interrupt.** `ch_done` in XFER produces a registered one-cycle `Interrupt` pulse on the cycle after the done.
  - On the same cycle, `irq_status[sel]` becomes 1.
  - If `irq_clr[sel]` arrives in the same cycle as the set, the set wins.
  - `irq_clr` on any other bit clears that bit the next cycle.
- **Stray done.** `ch_done` outside XFER is ignored.
- **Reset** (asynchronous, at `rst` low) forces state to IDLE. It forces `sel`, `rr_ptr`, `irq_status`, `ReqAck`, `Interrupt`, `Bus_Req`, `hold`, `Channel_en`, `con_en` and `con_sel` to 0.
  - A reset mid-XFER drops `Channel_en` and `Bus_Req` immediately, without waiting for the clock.

## Timing
- Request sampled in IDLE at edge N: `Bus_Req`/`hold` are high from cycle N+1.
- `Bus_Grant && C_config` sampled at edge M: `Channel_en`, `con_en` and `ReqAck` are high in cycle M+1. `ReqAck` lasts exactly one cycle.
- `ch_done` sampled at edge D: in cycle D+1, state is IDLE, `Channel_en`/`Bus_Req` are low, and `Interrupt` is high for one cycle.
  - A new arbitration can be sampled at edge D+1; `Bus_Req` rises again at D+2. Minimum gap between grants is 1 idle cycle.
- Grant loss sampled at edge G: `Channel_en` is low in cycle G+1 while `Bus_Req` stays high (REQ).
- Best-case latency: request to `Channel_en` is 2 cycles, with grant and config already high.

## Test plan
- **Fixed priority.** NUM_CH=4, ARB_MODE=0, `DmacReq=4'b0101`, grant after 3 cycles.
  - `con_sel=2`; `Channel_en=4'b0100`; `ReqAck=4'b0100` for 1 cycle.
  - After `ch_done`: `Interrupt` pulse and `irq_status=4'b0100`.
  - The next service is channel 0 (channel 2 is blocked until `irq_clr[2]`).
- **Round-robin.** ARB_MODE=1, `DmacReq=4'b1111` held, each `irq_status` bit cleared immediately on set.
  - Service order is 0,1,2,3,0.
  - `rr_ptr` wraps from 3 to 0.
- **Grant loss.** Drop `Bus_Grant` for 2 cycles mid-XFER on channel 1.
  - `Channel_en` goes low, `Bus_Req` stays high.
  - On re-grant, `Channel_en=4'b0010` again with no second `ReqAck`.
- **Simultaneous done and grant loss.** `ch_done` and `Bus_Grant` falling in the same cycle.
  - Next state is IDLE, with a single `Interrupt` pulse and no re-request for that channel.
- **Status set/clear collision.** `irq_clr[sel]` asserted on the `ch_done` cycle: `irq_status[sel]=1`.
  - A separate `irq_clr` a later cycle: the bit reads 0 the following cycle.
- **Asynchronous reset mid-transfer.** Assert `rst` low mid-XFER, away from any clock edge.
  - All outputs are 0 immediately, including `irq_status=0`.
  - After release, with `DmacReq=1`, channel 0 is served with `Bus_Req` high 1 cycle after sampling.
